// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite master bridge.
//   axil_state_e : transaction FSM states
//   OKAY/EXOKAY/SLVERR/DECERR : AXI response codes
//   is_active()  : true while the bus is owned by an in-flight transaction
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // States in which the watchdog accumulates cycles.
  function automatic logic is_active(input axil_state_e s);
    return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
  endfunction

endpackage

// File: rtl/axi4_lite_watchdog.sv
// Cycle watchdog for the AXI4-Lite master bridge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   active_i    : high while a transaction occupies the bus; low clears the count
//   expired_o   : registered, high during the LIMIT-th consecutive active cycle
module axi4_lite_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Count active cycles; expiry is flagged one cycle ahead so the output is a flop.
  always_comb begin
    cnt_d     = '0;
    expired_d = 1'b0;
    if (active_i) begin
      cnt_d     = cnt_q + CNT_W'(1);
      expired_d = (cnt_d == CNT_W'(LIMIT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/axi4_lite_master_bridge.sv
// AXI4-Lite master bridge: turns one command (valid/ready) into a single
// AXI4-Lite read or write and returns the outcome on a response port.
// One transaction in flight; every output is driven straight from a flop.
//   aclk, aresetn           : clock, asynchronous active-low reset
//   cmd_*                   : command in (write flag, addr, wdata, wstrb, prot)
//   rsp_*                   : response out (write flag, rdata, resp)
//   aw*/w*/b*/ar*/r*        : AXI4-Lite master channels
// Build option AXIL_TIMEOUT_EN: adds a TIMEOUT_CYC watchdog; on expiry the
// bridge reports SLVERR and later swallows the one stale B/R beat.
module axi4_lite_master_bridge
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  axil_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [2:0]        prot_q, prot_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              bready_q, bready_d;
  logic              rready_q, rready_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  // Set after a timeout: one late B or R beat is still owed by the slave.
  logic              drain_q, drain_d;

`ifdef AXIL_TIMEOUT_EN
  logic wdog_active;
  logic wdog_expired;

  assign wdog_active = is_active(state_q);

  axi4_lite_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (aclk),
    .rst_n     (aresetn),
    .active_i  (wdog_active),
    .expired_o (wdog_expired)
  );
`else
  localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    prot_d      = prot_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    drain_d     = drain_q;

    case (state_q)
      IDLE: begin
        if (drain_q) begin
          // Absorb and discard the stale beat, then reopen the command port.
          if ((bvalid && bready_q) || (rvalid && rready_q)) begin
            drain_d  = 1'b0;
            bready_d = 1'b0;
            rready_d = 1'b0;
          end
        end else if (cmd_valid && cmd_ready_q) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          prot_d    = cmd_prot;
          awvalid_d = cmd_write;
          wvalid_d  = cmd_write;
          arvalid_d = !cmd_write;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end
      end

      WR_REQ: begin
        // AW and W retire independently, in either order.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end

      RD_REQ: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_resp_d  = rresp;
          rsp_rdata_d = rdata;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (drain_q) begin
            bready_d = 1'b1;
            rready_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef AXIL_TIMEOUT_EN
    // A genuine completion in the expiry cycle wins over the timeout.
    if (wdog_expired && is_active(state_q) && (state_d != RSP)) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_write_d = (state_q == WR_REQ) || (state_q == WR_RESP);
      rsp_resp_d  = SLVERR;
      rsp_rdata_d = '0;
      drain_d     = 1'b1;
      state_d     = RSP;
    end
`endif

    cmd_ready_d = (state_d == IDLE) && !drain_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      prot_q      <= prot_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      drain_q     <= drain_d;
    end
  end

  // Address/prot are shared by AW and AR; only one of the two is ever valid.
  assign cmd_ready = cmd_ready_q;
  assign awaddr    = addr_q;
  assign awprot    = prot_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = addr_q;
  assign arprot    = prot_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed testbench for axi4_lite_master_bridge with a delay-programmable
// AXI4-Lite slave. Define AXIL_TIMEOUT_EN to also exercise the watchdog.
module tb_axi4_lite_master_bridge;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  axi4_lite_master_bridge #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .aclk      (aclk),      .aresetn   (aresetn),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),  .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata), .rsp_resp  (rsp_resp),
    .awaddr    (awaddr),    .awprot    (awprot),    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),     .wstrb     (wstrb),     .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),     .bvalid    (bvalid),    .bready    (bready),
    .araddr    (araddr),    .arprot    (arprot),    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),     .rresp     (rresp),     .rvalid    (rvalid),
    .rready    (rready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Slave model: each ready/valid rises after the programmed number of wait cycles.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  logic [1:0]  bresp_v = '0, rresp_v = '0;
  logic [31:0] rdata_v = '0;

  always @(negedge aclk) begin
    if (awvalid) begin awready = (aw_n >= aw_dly); aw_n = aw_n + 1; end
    else begin awready = 1'b0; aw_n = 0; end
    if (wvalid) begin wready = (w_n >= w_dly); w_n = w_n + 1; end
    else begin wready = 1'b0; w_n = 0; end
    if (arvalid) begin arready = (ar_n >= ar_dly); ar_n = ar_n + 1; end
    else begin arready = 1'b0; ar_n = 0; end
    if (bready) begin bvalid = (b_n >= b_dly); b_n = b_n + 1; end
    else begin bvalid = 1'b0; b_n = 0; end
    if (rready) begin rvalid = (r_n >= r_dly); r_n = r_n + 1; end
    else begin rvalid = 1'b0; r_n = 0; end
    bresp = bresp_v;
    rresp = rresp_v;
    rdata = rdata_v;
  end

  // Bus monitor: cycle counts per signal and payload seen at each handshake.
  int aw_hi = 0, w_hi = 0, b_hi = 0, ar_hi = 0, rsp_seen = 0, rsp_hs = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [2:0]  cap_awprot = '0, cap_arprot = '0;
  logic [1:0]  last_resp = '0;

  always @(posedge aclk) begin
    if (awvalid) aw_hi <= aw_hi + 1;
    if (wvalid)  w_hi  <= w_hi + 1;
    if (bready)  b_hi  <= b_hi + 1;
    if (arvalid) ar_hi <= ar_hi + 1;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
    if (awvalid && awready) begin cap_awaddr <= awaddr; cap_awprot <= awprot; end
    if (wvalid && wready)   begin cap_wdata <= wdata; cap_wstrb <= wstrb; end
    if (arvalid && arready) begin cap_araddr <= araddr; cap_arprot <= arprot; end
    if (rsp_valid && rsp_ready) begin rsp_hs <= rsp_hs + 1; last_resp <= rsp_resp; end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present a command and return 1 ns after the accepting edge.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    cmd_wstrb = s; cmd_prot = p;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // cyc counts cycles after the accept cycle (cycle 1 starts at the accept edge).
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 60) begin tick(); cyc++; end
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation still running, required finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    int b0, w0, a0, h0, s0;

    // Reset state: everything low while aresetn is asserted.
    #1 aresetn = 1'b0;
    #2;
    check("rst_outputs", {awvalid, wvalid, bready, arvalid, rready, cmd_ready,
                          rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 0);
    tick();
    tick();
    check("rst_cmd_ready_held", cmd_ready, 0);
    aresetn = 1'b1;
    tick();
    check("cmd_ready_after_release", cmd_ready, 1);

    // Read, arready delayed by 2, response held off for 5 cycles.
    ar_dly = 2; r_dly = 0; rdata_v = 32'hF0B4A596; rresp_v = 2'b00;
    rsp_ready = 1'b0;
    a0 = ar_hi;
    send(1'b0, 32'h20, 32'h0, 4'h0, 3'd5);
    wait_rsp(cyc);
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rdata", rsp_rdata, 32'hF0B4A596);
    check("rd_resp", rsp_resp, 2'b00);
    check("rd_write", rsp_write, 0);
    check("rd_araddr", cap_araddr, 32'h20);
    check("rd_arprot", cap_arprot, 3'd5);
    check("rd_arvalid_cycles", ar_hi - a0, 3);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rdata", rsp_rdata, 32'hF0B4A596);
      check("stall_write", rsp_write, 0);
      check("stall_cmd_ready", cmd_ready, 0);
      tick();
    end
    h0 = rsp_hs;
    rsp_ready = 1'b1;
    check("stall_6th_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1'b0;
    check("stall_release_valid", rsp_valid, 0);
    check("stall_release_cmd_ready", cmd_ready, 1);
    check("stall_one_handshake", rsp_hs - h0, 1);

    // Write with a zero-wait slave: minimum latency, rdata must read back zero.
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_v = 2'b00;
    a0 = aw_hi; w0 = w_hi;
    send(1'b1, 32'h10, 32'hF0B4A596, 4'b1011, 3'd3);
    wait_rsp(cyc);
    check("wr_latency", cyc, 3);
    check("wr_resp", rsp_resp, 2'b00);
    check("wr_write", rsp_write, 1);
    check("wr_rdata_zero", rsp_rdata, 0);
    check("wr_awvalid_cycles", aw_hi - a0, 1);
    check("wr_wvalid_cycles", w_hi - w0, 1);
    check("wr_awaddr", cap_awaddr, 32'h10);
    check("wr_awprot", cap_awprot, 3'd3);
    check("wr_wdata", cap_wdata, 32'hF0B4A596);
    check("wr_wstrb", cap_wstrb, 4'b1011);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_back_to_idle", cmd_ready, 1);

    // Write where W completes 4 cycles before AW, one B wait, SLVERR back.
    aw_dly = 4; w_dly = 0; b_dly = 1; bresp_v = 2'b10;
    rsp_ready = 1'b1;
    a0 = aw_hi; w0 = w_hi; b0 = b_hi; h0 = rsp_hs;
    send(1'b1, 32'h44, 32'h1234_5678, 4'hF, 3'd0);
    n = 0;
    while (!cmd_ready && n < 60) begin tick(); n++; end
    rsp_ready = 1'b0;
    check("skew_done", cmd_ready, 1);
    check("skew_awvalid_cycles", aw_hi - a0, 5);
    check("skew_wvalid_cycles", w_hi - w0, 1);
    check("skew_bready_cycles", b_hi - b0, 2);
    check("skew_one_response", rsp_hs - h0, 1);
    check("skew_resp", last_resp, 2'b10);
    check("skew_awaddr", cap_awaddr, 32'h44);
    check("skew_wdata", cap_wdata, 32'h1234_5678);

    // Reset asserted for 48 ns while waiting for B.
    aw_dly = 0; b_dly = 1000; bresp_v = 2'b00;
    send(1'b1, 32'h30, 32'hDEAD_BEEF, 4'hF, 3'd1);
    n = 0;
    while (!bready && n < 20) begin tick(); n++; end
    check("rst_in_wr_resp", bready, 1);
    tick();
    #2 aresetn = 1'b0;
    #1;
    check("rst_async_outputs", {awvalid, wvalid, bready, arvalid, rready, cmd_ready,
                                rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 0);
    check("rst_async_awaddr", awaddr, 0);
    #47 aresetn = 1'b1;
    b_dly = 0;
    s0 = rsp_seen;
    tick();
    check("rst_release_cmd_ready", cmd_ready, 1);
    repeat (8) tick();
    check("rst_no_response", rsp_seen - s0, 0);
    check("rst_bready_low", bready, 0);

`ifdef AXIL_TIMEOUT_EN
    // Watchdog: B never arrives, SLVERR after 16 cycles, late B swallowed.
    aw_dly = 0; w_dly = 0; b_dly = 1000;
    rsp_ready = 1'b0;
    send(1'b1, 32'h80, 32'hA5A5_A5A5, 4'hF, 3'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
    check("tmo_latency", cyc, 16);
    check("tmo_resp", rsp_resp, 2'b10);
    check("tmo_rdata", rsp_rdata, 0);
    check("tmo_write", rsp_write, 1);
    check("tmo_bready_dropped", bready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("tmo_drain_bready", bready, 1);
    check("tmo_drain_rready", rready, 1);
    check("tmo_drain_cmd_ready", cmd_ready, 0);
    tick();
    check("tmo_drain_hold", cmd_ready, 0);
    b_dly = 0;
    s0 = rsp_seen;
    n = 0;
    while (!cmd_ready && n < 10) begin tick(); n++; end
    check("tmo_absorbed_cmd_ready", cmd_ready, 1);
    check("tmo_absorbed_bready", bready, 0);
    check("tmo_no_extra_rsp", rsp_seen - s0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
